// File: rtl/axi_lite_mailbox.sv
// rtl/axi_lite_mailbox.sv - AXI-lite MMIO word mailbox between core and host agent
//
// Purpose: core writes to TXDATA push into a TX FIFO that the host drains over a
// valid/ready stream; the host pushes into an RX FIFO that the core pops by
// reading RXDATA. STATUS exposes full/empty flags and counts, CTRL holds irq_en
// and a self-clearing flush. irq is a registered level of irq_en & ~rx_empty.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_aw*/s_w*/s_b*          AXI-lite write address/data/response channels
//   s_ar*/s_r*               AXI-lite read address/data channels
//   h_tx_data/valid/ready    TX FIFO head toward the host
//   h_rx_data/valid/ready    host words into the RX FIFO
//   irq                      registered level interrupt
module axi_lite_mailbox #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   h_tx_data,
  output logic                    h_tx_valid,
  input  logic                    h_tx_ready,
  input  logic [DATA_WIDTH-1:0]   h_rx_data,
  input  logic                    h_rx_valid,
  output logic                    h_rx_ready,
  output logic                    irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] A_TXDATA = 2'd0;
  localparam logic [1:0] A_RXDATA = 2'd1;
  localparam logic [1:0] A_STATUS = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [DATA_WIDTH-1:0] tx_mem [DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem [DEPTH];
  logic [PW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [CW-1:0] tx_count, rx_count;
  logic          irq_en;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic aw_hs, ar_hs;
  logic tx_push, tx_pop, rx_push, rx_pop, flush_now;
  logic [1:0] waddr, raddr;
  logic [DATA_WIDTH-1:0] status;

  assign waddr    = s_awaddr[4:3];
  assign raddr    = s_araddr[4:3];
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  // Bits outside the decoded address field and the byte strobes are not used.
  logic unused_bits;
  assign unused_bits = ^{s_wstrb, s_awaddr[ADDR_WIDTH-1:5], s_awaddr[2:0],
                         s_araddr[ADDR_WIDTH-1:5], s_araddr[2:0]};

  // ---------------- write FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next    = w_state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    aw_hs     = 1'b0;
    case (w_state)
      W_IDLE: begin
        // Address and data are only taken together.
        aw_hs     = ~rst & s_awvalid & s_wvalid;
        s_awready = aw_hs;
        s_wready  = aw_hs;
        if (aw_hs) w_next = W_RESP;
      end
      W_RESP: if (s_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  assign s_bvalid = (w_state == W_RESP);

  // ---------------- read FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next    = r_state;
    s_arready = 1'b0;
    ar_hs     = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_arready = ~rst;
        ar_hs     = ~rst & s_arvalid;
        if (ar_hs) r_next = R_RESP;
      end
      R_RESP: if (s_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  assign s_rvalid = (r_state == R_RESP);

  // ---------------- FIFO control ----------------
  // Flush wins over any host-side transfer in its handshake cycle.
  assign flush_now  = aw_hs & (waddr == A_CTRL) & s_wdata[1];
  assign tx_push    = aw_hs & (waddr == A_TXDATA) & ~tx_full;
  assign tx_pop     = ~tx_empty & h_tx_ready & ~flush_now;
  assign h_rx_ready = ~rx_full & ~flush_now;
  assign rx_push    = h_rx_valid & h_rx_ready;
  assign rx_pop     = ar_hs & (raddr == A_RXDATA) & ~rx_empty;

  assign h_tx_valid = ~tx_empty;
  assign h_tx_data  = tx_mem[tx_rd];

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= s_wdata;
    if (rx_push) rx_mem[rx_wr] <= h_rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_rd <= '0; tx_wr <= '0; tx_count <= '0;
      rx_rd <= '0; rx_wr <= '0; rx_count <= '0;
    end else if (flush_now) begin
      tx_rd <= '0; tx_wr <= '0; tx_count <= '0;
      rx_rd <= '0; rx_wr <= '0; rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      if (tx_push & ~tx_pop)      tx_count <= tx_count + 1'b1;
      else if (tx_pop & ~tx_push) tx_count <= tx_count - 1'b1;
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      if (rx_push & ~rx_pop)      rx_count <= rx_count + 1'b1;
      else if (rx_pop & ~rx_push) rx_count <= rx_count - 1'b1;
    end
  end

  // ---------------- registers and responses ----------------
  always_comb begin
    status        = '0;
    status[0]     = tx_full;
    status[1]     = tx_empty;
    status[2]     = rx_full;
    status[3]     = rx_empty;
    status[15:8]  = 8'(tx_count);
    status[23:16] = 8'(rx_count);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_bresp <= OKAY;
      irq_en  <= 1'b0;
      irq     <= 1'b0;
      s_rdata <= '0;
      s_rresp <= OKAY;
    end else begin
      irq <= irq_en & ~rx_empty;
      if (aw_hs) begin
        s_bresp <= (waddr == A_TXDATA && tx_full) ? SLVERR : OKAY;
        if (waddr == A_CTRL) irq_en <= s_wdata[0];
      end
      if (ar_hs) begin
        s_rresp <= OKAY;
        case (raddr)
          A_TXDATA: s_rdata <= '0;
          A_RXDATA: begin
            if (rx_empty) begin
              s_rdata <= '0;
              s_rresp <= SLVERR;
            end else begin
              s_rdata <= rx_mem[rx_rd];
            end
          end
          A_STATUS: s_rdata <= status;
          default:  s_rdata <= {{(DATA_WIDTH-1){1'b0}}, irq_en};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_mailbox.sv
// tb/tb_axi_lite_mailbox.sv - self-checking bench for axi_lite_mailbox
module tb_axi_lite_mailbox;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [63:0] s_wdata = '0;
  logic [7:0]  s_wstrb = 8'hff;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [63:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [63:0] h_tx_data;
  logic        h_tx_valid;
  logic        h_tx_ready = 1'b0;
  logic [63:0] h_rx_data = '0;
  logic        h_rx_valid = 1'b0;
  logic        h_rx_ready;
  logic        irq;

  axi_lite_mailbox #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .h_tx_data(h_tx_data), .h_tx_valid(h_tx_valid), .h_tx_ready(h_tx_ready),
    .h_rx_data(h_rx_data), .h_rx_valid(h_rx_valid), .h_rx_ready(h_rx_ready),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: plain queues plus the interrupt enable bit.
  logic [63:0] txq[$];
  logic [63:0] rxq[$];
  bit          irq_en_m = 1'b0;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Only addr[4:3] selects a register; scramble everything else.
  function automatic logic [63:0] mk_addr(input int idx);
    logic [63:0] a;
    a = rnd64() & ~64'h18;
    return a | (64'(idx) << 3);
  endfunction

  function automatic logic [63:0] exp_status();
    logic [63:0] s;
    s = '0;
    s[0]     = (txq.size() == DEPTH);
    s[1]     = (txq.size() == 0);
    s[2]     = (rxq.size() == DEPTH);
    s[3]     = (rxq.size() == 0);
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, output logic [1:0] resp);
    @(negedge clk);
    s_awaddr = a; s_wdata = d; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1 check("awready", s_awready, 1);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("bvalid", s_bvalid, 1);
    resp = s_bresp;
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    check("bvalid_clr", s_bvalid, 0);
  endtask

  task automatic axi_read(input logic [63:0] a, output logic [63:0] d, output logic [1:0] resp);
    @(negedge clk);
    s_araddr = a; s_arvalid = 1'b1;
    #1 check("arready", s_arready, 1);
    @(negedge clk);
    s_arvalid = 1'b0;
    check("rvalid", s_rvalid, 1);
    d = s_rdata; resp = s_rresp;
    s_rready = 1'b1;
    @(negedge clk);
    s_rready = 1'b0;
    check("rvalid_clr", s_rvalid, 0);
  endtask

  task automatic do_write(input int idx, input logic [63:0] d);
    logic [1:0] r, er;
    er = 2'd0;
    if (idx == 0) begin
      if (txq.size() == DEPTH) er = 2'd2;
      else txq.push_back(d);
    end else if (idx == 3) begin
      irq_en_m = d[0];
      if (d[1]) begin txq.delete(); rxq.delete(); end
    end
    axi_write(mk_addr(idx), d, r);
    check($sformatf("bresp[%0d]", idx), r, er);
  endtask

  task automatic do_read(input int idx);
    logic [63:0] d, ed;
    logic [1:0]  r, er;
    er = 2'd0; ed = '0;
    case (idx)
      1: if (rxq.size() == 0) er = 2'd2; else ed = rxq.pop_front();
      2: ed = exp_status();
      3: ed = 64'(irq_en_m);
      default: ed = '0;
    endcase
    axi_read(mk_addr(idx), d, r);
    check($sformatf("rdata[%0d]", idx), d, ed);
    check($sformatf("rresp[%0d]", idx), r, er);
  endtask

  task automatic host_push(input logic [63:0] d);
    bit acc;
    @(negedge clk);
    h_rx_data = d; h_rx_valid = 1'b1;
    acc = (rxq.size() < DEPTH);
    #1 check("h_rx_ready", h_rx_ready, acc);
    if (acc) rxq.push_back(d);
    @(negedge clk);
    h_rx_valid = 1'b0;
  endtask

  task automatic host_pop();
    @(negedge clk);
    check("h_tx_valid", h_tx_valid, txq.size() != 0);
    if (txq.size() != 0) check("h_tx_data", h_tx_data, txq.pop_front());
    h_tx_ready = 1'b1;
    @(negedge clk);
    h_tx_ready = 1'b0;
  endtask

  task automatic check_irq();
    @(negedge clk);
    check("irq", irq, irq_en_m && rxq.size() != 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    logic [1:0]  r;

    // Reset state
    #2;
    check("rst_awready", s_awready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_irq", irq, 0);
    check("rst_txvalid", h_tx_valid, 0);
    check("rst_rdata", s_rdata, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single TX push
    do_write(0, 64'h1122334455667788);
    check("tx1_valid", h_tx_valid, 1);
    check("tx1_data", h_tx_data, 64'h1122334455667788);
    do_read(2);
    host_pop();

    // Fill TX, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) do_write(0, 64'(i));
    do_read(2);
    do_write(0, 64'hdead);
    do_read(2);
    h_tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) host_pop();
    host_pop();

    // RX empty read, then two words
    do_read(1);
    host_push(64'hA5);
    host_push(64'h5A);
    do_read(1);
    do_read(1);
    do_read(2);

    // Interrupt timing
    do_write(3, 64'h1);
    host_push(64'h77);
    check("irq_lag", irq, 0);
    @(negedge clk);
    check("irq_set", irq, 1);
    do_read(1);
    check("irq_clr", irq, 0);

    // Flush with host holding a push
    do_write(0, 64'h42);
    host_push(64'h43);
    @(negedge clk);
    h_rx_valid = 1'b1; h_rx_data = 64'h99;
    s_awaddr = mk_addr(3); s_wdata = 64'h3; s_awvalid = 1'b1; s_wvalid = 1'b1;
    #1 check("flush_rx_ready", h_rx_ready, 0);
    check("flush_awready", s_awready, 1);
    @(negedge clk);
    h_rx_valid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
    check("flush_bvalid", s_bvalid, 1);
    check("flush_bresp", s_bresp, 0);
    s_bready = 1'b1;
    @(negedge clk);
    s_bready = 1'b0;
    txq.delete(); rxq.delete(); irq_en_m = 1'b1;
    do_read(2);
    do_read(3);

    // Reset in the middle of outstanding responses
    do_write(0, 64'h1); do_write(0, 64'h2);
    host_push(64'h3); host_push(64'h4);
    check_irq();
    check("pre_rst_irq", irq, 1);
    @(negedge clk);
    s_awaddr = mk_addr(0); s_wdata = 64'h5; s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = mk_addr(2); s_arvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    check("mid_bvalid", s_bvalid, 1);
    check("mid_rvalid", s_rvalid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_bvalid", s_bvalid, 0);
    check("arst_rvalid", s_rvalid, 0);
    check("arst_irq", irq, 0);
    check("arst_txvalid", h_tx_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    txq.delete(); rxq.delete(); irq_en_m = 1'b0;
    do_read(2);
    check("post_rst_txvalid", h_tx_valid, 0);

    // Randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      int op;
      check_irq();
      op = $urandom_range(0, 9);
      case (op)
        0, 1: host_push(rnd64());
        2, 3: host_pop();
        4, 5: do_write(0, rnd64());
        6:    do_read(1);
        7:    do_read(2);
        8: begin
          d = 64'($urandom_range(0, 1));
          if ($urandom_range(0, 7) == 0) d[1] = 1'b1;
          do_write(3, d);
        end
        default: begin
          case ($urandom_range(0, 3))
            0: do_read(0);
            1: do_write(1, rnd64());
            2: do_write(2, rnd64());
            default: do_read(3);
          endcase
        end
      endcase
    end
    do_read(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
